mandel_scheduler: RTL and testbench

//  Pixel scheduler that shares CORES mandelbrot iteration engines across one framebuffer render.

---
 rtl/mandel_scheduler_if.sv | 31 +++
 rtl/mandel_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_mandel_scheduler.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mandel_scheduler_if.sv
// Engine bus and pixel stream bundle for mandel_scheduler.
// master: scheduler side; slave: engines plus draw stage.
interface mandel_scheduler_if #(
   parameter int CORES    = 4,
   parameter int CORDW    = 16,
   parameter int FP_WIDTH = 25,
   parameter int ITERW    = 8
);
   logic [CORES-1:0]          core_start;
   logic signed [FP_WIDTH-1:0] core_re;
   logic signed [FP_WIDTH-1:0] core_im;
   logic [CORES-1:0]          core_done;
   logic [CORES*ITERW-1:0]    core_iter;
   logic                      pix_valid;
   logic                      pix_ready;
   logic signed [CORDW-1:0]   pix_x;
   logic signed [CORDW-1:0]   pix_y;
   logic [ITERW-1:0]          pix_iter;

   modport master (
      output core_start, core_re, core_im,
      output pix_valid, pix_x, pix_y, pix_iter,
      input  core_done, core_iter, pix_ready
   );

   modport slave (
      input  core_start, core_re, core_im,
      input  pix_valid, pix_x, pix_y, pix_iter,
      output core_done, core_iter, pix_ready
   );
endinterface

// File: rtl/mandel_scheduler.sv
// Mandelbrot pixel scheduler: raster-scans a frame, dispatches pixel
// coordinates to CORES shared engines and streams tagged results out.
// Ports: clk, rst_n (async low), start, x_start/y_start/step (signed
// fixed point), bus (engine start/re/im/done/iter + pixel valid/ready
// stream with x/y/iter), busy (RUN or DRAIN), done (one-cycle pulse).
module mandel_scheduler #(
   parameter int CORES     = 4,
   parameter int CORDW     = 16,
   parameter int FB_WIDTH  = 320,
   parameter int FB_HEIGHT = 180,
   parameter int FP_WIDTH  = 25,
   parameter int ITER_MAX  = 255,
   localparam int ITERW    = $clog2(ITER_MAX + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic signed [FP_WIDTH-1:0] x_start,
   input  logic signed [FP_WIDTH-1:0] y_start,
   input  logic signed [FP_WIDTH-1:0] step,
   mandel_scheduler_if.master         bus,
   output logic                       busy,
   output logic                       done
);
   localparam int IW = (CORES > 1) ? $clog2(CORES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
   typedef enum logic [1:0] {SL_FREE, SL_BUSY, SL_RESULT} slot_t;

   state_t state_q, state_d;

   slot_t                slot_st   [CORES];
   logic [CORDW-1:0]     slot_x    [CORES];
   logic [CORDW-1:0]     slot_y    [CORES];
   logic [ITERW-1:0]     slot_iter [CORES];

   logic [CORDW-1:0]           x_cnt, y_cnt;
   logic signed [FP_WIDTH-1:0] fx, fy, xs_q, step_q;

   logic [IW-1:0]    last_q;
   logic             pv_q;
   logic [CORDW-1:0] px_q, py_q;
   logic [ITERW-1:0] pi_q;

   logic          disp_hit, dispatch, last_pix, all_free;
   logic [IW-1:0] disp_idx;
   logic          gnt_hit, grant, out_load;
   logic [IW-1:0] gnt_idx, j;

   // Lowest-index free slot; slots freed by this cycle's grant are
   // still RESULT here, so they are only reused next cycle.
   always_comb begin
      disp_hit = 1'b0;
      disp_idx = '0;
      all_free = 1'b1;
      for (int i = CORES - 1; i >= 0; i--) begin
         if (slot_st[i] == SL_FREE) begin
            disp_hit = 1'b1;
            disp_idx = IW'(i);
         end else begin
            all_free = 1'b0;
         end
      end
   end

   assign dispatch = (state_q == S_RUN) && disp_hit;
   assign last_pix = (x_cnt == CORDW'(FB_WIDTH - 1)) &&
                     (y_cnt == CORDW'(FB_HEIGHT - 1));

   // Round-robin search starting just after the last granted slot;
   // scanning backwards lets the nearest candidate win.
   always_comb begin
      gnt_hit = 1'b0;
      gnt_idx = '0;
      j       = '0;
      for (int k = CORES; k >= 1; k--) begin
         j = IW'((int'(last_q) + k) % CORES);
         if (slot_st[j] == SL_RESULT) begin
            gnt_hit = 1'b1;
            gnt_idx = j;
         end
      end
   end

   assign out_load = !pv_q || bus.pix_ready;
   assign grant    = out_load && gnt_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      busy           = 1'b0;
      done           = 1'b0;
      bus.core_start = '0;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (dispatch) bus.core_start = CORES'(1) << disp_idx;
            if (dispatch && last_pix) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (all_free && !pv_q) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.core_re = fx;
   assign bus.core_im = fy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt  <= '0;
         y_cnt  <= '0;
         fx     <= '0;
         fy     <= '0;
         xs_q   <= '0;
         step_q <= '0;
      end else if (state_q == S_IDLE && start) begin
         x_cnt  <= '0;
         y_cnt  <= '0;
         fx     <= x_start;
         fy     <= y_start;
         xs_q   <= x_start;
         step_q <= step;
      end else if (dispatch) begin
         if (x_cnt == CORDW'(FB_WIDTH - 1)) begin
            x_cnt <= '0;
            fx    <= xs_q;
            y_cnt <= y_cnt + CORDW'(1);
            fy    <= fy + step_q;
         end else begin
            x_cnt <= x_cnt + CORDW'(1);
            fx    <= fx + step_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CORES; i++) begin
            slot_st[i]   <= SL_FREE;
            slot_x[i]    <= '0;
            slot_y[i]    <= '0;
            slot_iter[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CORES; i++) begin
            if (dispatch && disp_idx == IW'(i)) begin
               slot_st[i] <= SL_BUSY;
               slot_x[i]  <= x_cnt;
               slot_y[i]  <= y_cnt;
            end else if (slot_st[i] == SL_BUSY && bus.core_done[i]) begin
               slot_st[i]   <= SL_RESULT;
               slot_iter[i] <= bus.core_iter[i*ITERW +: ITERW];
            end else if (grant && gnt_idx == IW'(i)) begin
               slot_st[i] <= SL_FREE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv_q   <= 1'b0;
         px_q   <= '0;
         py_q   <= '0;
         pi_q   <= '0;
         last_q <= '0;
      end else if (out_load) begin
         pv_q <= gnt_hit;
         if (gnt_hit) begin
            px_q   <= slot_x[gnt_idx];
            py_q   <= slot_y[gnt_idx];
            pi_q   <= slot_iter[gnt_idx];
            last_q <= gnt_idx;
         end
      end
   end

   assign bus.pix_valid = pv_q;
   assign bus.pix_x     = px_q;
   assign bus.pix_y     = py_q;
   assign bus.pix_iter  = pi_q;
endmodule

// File: tb/tb_mandel_scheduler.sv
// Bench for mandel_scheduler: 4x2 frame, four fixed-latency engines,
// scoreboard of tags/coordinates plus directed ordering expectations.
module tb_mandel_scheduler;
   localparam int CORES = 4;
   localparam int CORDW = 16;
   localparam int W     = 4;
   localparam int H     = 2;
   localparam int NPIX  = W * H;
   localparam int FPW   = 25;
   localparam int ITERW = 8;
   localparam int FRAC  = 21;
   localparam logic signed [FPW-1:0] ONE = 25'sd2097152;
   localparam logic signed [FPW-1:0] XS  = -25'sd4194304;
   localparam logic signed [FPW-1:0] YS  = -25'sd2097152;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic signed [FPW-1:0] x_start, y_start, step;
   logic busy, done;

   mandel_scheduler_if #(
      .CORES(CORES), .CORDW(CORDW), .FP_WIDTH(FPW), .ITERW(ITERW)
   ) bus ();

   mandel_scheduler #(
      .CORES(CORES), .CORDW(CORDW), .FB_WIDTH(W), .FB_HEIGHT(H),
      .FP_WIDTH(FPW), .ITER_MAX(255)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .x_start(x_start), .y_start(y_start), .step(step),
      .bus(bus), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [ITERW-1:0] f_iter(
      input logic signed [FPW-1:0] re,
      input logic signed [FPW-1:0] im);
      int r, i;
      r = int'(re >>> FRAC);
      i = int'(im >>> FRAC);
      return ITERW'(r * 3 + i * 7 + 40);
   endfunction

   function automatic logic signed [FPW-1:0] coord(
      input logic signed [FPW-1:0] base, input int n);
      return FPW'(longint'(base) + longint'(n) * longint'(ONE));
   endfunction

   // stimulus-owned controls
   int lat [CORES] = '{5, 5, 5, 5};
   int test_id = 0;
   int frame_id = 0;
   int timeout_req = 0;
   bit expect_busy = 1'b0;
   bit expect_idle = 1'b0;
   bit probe = 1'b0;

   // engines: fixed latency, result from the coordinate they received
   int ecnt [CORES] = '{default: 0};
   logic [ITERW-1:0] eval [CORES];
   always @(negedge clk) begin
      for (int i = 0; i < CORES; i++) begin
         bus.core_done[i] = 1'b0;
         bus.core_iter[i*ITERW +: ITERW] = '0;
         if (ecnt[i] == 1) begin
            bus.core_done[i] = 1'b1;
            bus.core_iter[i*ITERW +: ITERW] = eval[i];
         end
         if (ecnt[i] > 0) ecnt[i] = ecnt[i] - 1;
         if (bus.core_start[i]) begin
            ecnt[i] = lat[i];
            eval[i] = f_iter(bus.core_re, bus.core_im);
         end
      end
   end

   int npass = 0;
   int ntot = 0;

   task automatic chk(input bit ok, input string name,
                      input longint act, input longint exp);
      ntot++;
      if (ok) npass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                    name, act, exp, cyc);
   endtask

   int ord2 [4] = '{1, 2, 3, 0};
   int ord3 [8] = '{1, 2, 3, 0, 4, 5, 6, 7};

   int cur_frame = 0, start_cyc = 0, disp_cnt = 0, pix_cnt = 0;
   int last_hs = 0, tout_seen = 0, tag;
   bit seen [NPIX];
   bit prev_v = 0, prev_r = 0, prev_done = 0;
   logic [CORDW-1:0] prev_x, prev_y;
   logic [ITERW-1:0] prev_i;

   always @(negedge clk) begin
      if (frame_id != cur_frame) begin
         cur_frame = frame_id;
         start_cyc = cyc;
         disp_cnt  = 0;
         pix_cnt   = 0;
         seen      = '{default: 1'b0};
      end
      if (!rst_n) begin
         chk(bus.core_start == 0 && !bus.pix_valid && !busy && !done &&
             bus.pix_x == 0 && bus.pix_y == 0 && bus.pix_iter == 0 &&
             bus.core_re == 0 && bus.core_im == 0,
             "reset_zero", {busy, done, bus.pix_valid}, 0);
         prev_v    = 1'b0;
         prev_done = 1'b0;
      end else begin
         if (timeout_req != tout_seen) begin
            tout_seen = timeout_req;
            chk(1'b0, "done_timeout", 0, 1);
         end
         if (expect_idle)
            chk(!busy && bus.core_start == 0 && !bus.pix_valid && !done,
                "idle_quiet", {busy, bus.pix_valid, bus.core_start}, 0);
         if (expect_busy && !done) chk(busy, "busy", busy, 1);
         if (bus.core_start != 0) begin
            chk($onehot(bus.core_start), "onehot", bus.core_start, 1);
            if (disp_cnt >= NPIX) begin
               chk(1'b0, "extra_dispatch", disp_cnt + 1, NPIX);
            end else begin
               if (disp_cnt == 0)
                  chk(cyc == start_cyc + 1, "first_dispatch",
                      cyc - start_cyc, 1);
               chk(bus.core_re == coord(XS, disp_cnt % W), "disp_re",
                   bus.core_re, coord(XS, disp_cnt % W));
               chk(bus.core_im == coord(YS, disp_cnt / W), "disp_im",
                   bus.core_im, coord(YS, disp_cnt / W));
               if (test_id == 2 && disp_cnt == 3)
                  chk(bus.core_re == 25'sd2097152, "re_x3",
                      bus.core_re, 2097152);
            end
            disp_cnt++;
         end
         if (prev_v && !prev_r)
            chk(bus.pix_valid && bus.pix_x == prev_x &&
                bus.pix_y == prev_y && bus.pix_iter == prev_i,
                "stall_hold", {bus.pix_valid, bus.pix_x}, {1'b1, prev_x});
         if (bus.pix_valid && bus.pix_ready) begin
            if (bus.pix_x < 0 || bus.pix_x >= W ||
                bus.pix_y < 0 || bus.pix_y >= H) begin
               chk(1'b0, "tag_range", bus.pix_x, 0);
            end else begin
               tag = int'(bus.pix_x) + W * int'(bus.pix_y);
               chk(!seen[tag], "dup_pixel", tag, -1);
               seen[tag] = 1'b1;
               chk(bus.pix_iter == f_iter(coord(XS, int'(bus.pix_x)),
                                          coord(YS, int'(bus.pix_y))),
                   "iter", bus.pix_iter,
                   f_iter(coord(XS, int'(bus.pix_x)),
                          coord(YS, int'(bus.pix_y))));
               if (test_id == 1 && tag == 0)
                  chk(bus.pix_iter == 8'd27, "iter_x0y0", bus.pix_iter, 27);
               if (test_id == 2 && tag == 3)
                  chk(bus.pix_iter == 8'd36, "iter_x3y0", bus.pix_iter, 36);
               if (test_id == 2 && pix_cnt < 4)
                  chk(tag == ord2[pix_cnt], "order2", tag, ord2[pix_cnt]);
               if (test_id == 3 && pix_cnt < 8)
                  chk(tag == ord3[pix_cnt], "order3", tag, ord3[pix_cnt]);
            end
            pix_cnt++;
            last_hs = cyc;
         end
         if (done) begin
            chk(!prev_done, "done_pulse", 1, 0);
            chk(pix_cnt == NPIX, "frame_pixels", pix_cnt, NPIX);
            chk(disp_cnt == NPIX, "frame_dispatch", disp_cnt, NPIX);
            chk(cyc == last_hs + 2, "done_latency", cyc - last_hs, 2);
         end
         if (probe)
            chk(disp_cnt == 5 && bus.pix_valid && bus.core_start == 0,
                "stall_dispatch", disp_cnt, 5);
         prev_v    = bus.pix_valid;
         prev_r    = bus.pix_ready;
         prev_x    = bus.pix_x;
         prev_y    = bus.pix_y;
         prev_i    = bus.pix_iter;
         prev_done = done;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic begin_frame();
      start = 1'b1;
      frame_id++;
      tick();
      start = 1'b0;
      expect_busy = 1'b1;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      if (!done) timeout_req++;
      expect_busy = 1'b0;
   endtask

   initial begin
      x_start = XS;
      y_start = YS;
      step = ONE;
      bus.pix_ready = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      test_id = 1;
      begin_frame();
      wait_done(300);
      tick();

      test_id = 2;
      lat = '{9, 3, 3, 3};
      begin_frame();
      wait_done(300);
      tick();

      test_id = 3;
      lat = '{15, 6, 5, 4};
      begin_frame();
      wait_done(300);
      tick();

      test_id = 4;
      lat = '{5, 5, 5, 5};
      bus.pix_ready = 1'b0;
      begin_frame();
      repeat (19) tick();
      probe = 1'b1;
      tick();
      probe = 1'b0;
      bus.pix_ready = 1'b1;
      wait_done(300);
      tick();

      test_id = 5;
      begin_frame();
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(300);
      start = 1'b1;
      tick();
      start = 1'b0;
      expect_idle = 1'b1;
      repeat (6) tick();
      expect_idle = 1'b0;

      begin_frame();
      repeat (6) tick();
      rst_n = 1'b0;
      expect_busy = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      expect_idle = 1'b1;
      repeat (20) tick();
      expect_idle = 1'b0;

      begin_frame();
      wait_done(300);
      repeat (3) tick();

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
